// File: rtl/uart_prog_loader_pkg.sv
// uart_prog_loader_pkg: shared state encodings and default constants for the UART program loader
package uart_prog_loader_pkg;
  localparam int CLKS_PER_BIT_SIM = 16;
  localparam int CLKS_PER_BIT_SYN = 434;
  localparam logic [7:0] HEADER_DEF = 8'hA5;
  typedef enum logic [1:0] {ST_IDLE, ST_LEN, ST_DATA, ST_CSUM} ld_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_prog_loader_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with start-bit glitch rejection and framing error pulse
module uart_rx
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_SIM
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_ferr
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  logic [1:0] r_sync;
  logic r_prev;
  rx_state_t r_state, w_state_n;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic w_rx, w_tick;
  assign w_rx = r_sync[1];
  assign w_tick = (r_state == RX_START) ? (r_cnt == HALF) : (r_cnt == FULL);
  assign rx_byte = r_shift;
  // next state: idle waits for a falling edge, start re-checks mid-bit, then 8 data bits and a stop bit
  always_comb begin
    w_state_n = (r_state == RX_IDLE) ? ((r_prev && !w_rx) ? RX_START : RX_IDLE)
              : !w_tick ? r_state
              : (r_state == RX_START) ? (w_rx ? RX_IDLE : RX_DATA)
              : (r_state == RX_DATA) ? ((r_bit == 3'd7) ? RX_STOP : RX_DATA)
              : RX_IDLE;
  end
  // synchronizer, bit timer, shift register and one-cycle result pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= 2'b11;
      r_prev   <= 1'b1;
      r_state  <= RX_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], rxd};
      r_prev   <= w_rx;
      r_state  <= w_state_n;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      r_cnt    <= (r_state == RX_IDLE || w_tick) ? '0 : r_cnt + 1'b1;
      if (r_state == RX_DATA && w_tick) begin
        r_shift <= {w_rx, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
      if (r_state == RX_STOP && w_tick) begin
        rx_valid <= w_rx;
        rx_ferr  <= !w_rx;
      end
    end
  end
endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: parses HEADER/LEN/DATA/CSUM frames from UART and writes the data bytes into program RAM
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = CLKS_PER_BIT_SIM,
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter logic [7:0]  HEADER       = HEADER_DEF,
  parameter int          TIMEOUT_CYC  = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        load_en,
  output logic [15:0] ld_addr,
  output logic [7:0]  ld_data,
  output logic        ld_write,
  output logic        ld_busy,
  output logic        ld_done,
  output logic        ld_err,
  output logic [7:0]  ld_count
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic w_rx_valid, w_rx_ferr;
  logic [7:0] w_rx_byte;
  ld_state_t r_state, w_state_n;
  logic [8:0] r_rem;
  logic [7:0] r_sum;
  logic [TW-1:0] r_to;
  logic w_busy, w_timeout, w_abort, w_start, w_byte;
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rx_valid (w_rx_valid),
    .rx_byte  (w_rx_byte),
    .rx_ferr  (w_rx_ferr)
  );
  assign w_busy    = r_state != ST_IDLE;
  assign w_timeout = w_busy && !w_rx_valid && (r_to == TW'(TIMEOUT_CYC - 1));
  assign w_abort   = w_busy && (w_rx_ferr || w_timeout || !load_en);
  assign w_start   = (r_state == ST_IDLE) && w_rx_valid && (w_rx_byte == HEADER) && load_en;
  assign w_byte    = w_busy && w_rx_valid && !w_abort;
  assign ld_busy   = w_busy;
  // next state: any error returns to idle, otherwise each accepted byte advances the frame
  always_comb begin
    w_state_n = w_abort ? ST_IDLE
              : w_start ? ST_LEN
              : !w_byte ? r_state
              : (r_state == ST_LEN) ? ST_DATA
              : (r_state == ST_DATA) ? ((r_rem == 9'd1) ? ST_CSUM : ST_DATA)
              : ST_IDLE;
  end
  // frame datapath: inter-byte timeout, RAM write strobe, running checksum and sticky status
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_rem    <= '0;
      r_sum    <= '0;
      r_to     <= '0;
      ld_addr  <= '0;
      ld_data  <= '0;
      ld_write <= 1'b0;
      ld_done  <= 1'b0;
      ld_err   <= 1'b0;
      ld_count <= '0;
    end else begin
      r_state  <= w_state_n;
      ld_write <= 1'b0;
      r_to     <= (!w_busy || w_rx_valid) ? '0 : r_to + 1'b1;
      if (w_start) begin
        ld_done  <= 1'b0;
        ld_err   <= 1'b0;
        ld_count <= '0;
        r_sum    <= '0;
      end
      if (w_abort) ld_err <= 1'b1;
      if (w_byte && r_state == ST_LEN) begin
        r_rem <= (w_rx_byte == 8'h00) ? 9'd256 : {1'b0, w_rx_byte};
      end else if (w_byte && r_state == ST_DATA) begin
        ld_write <= 1'b1;
        ld_addr  <= BASE_ADDR + {8'h00, ld_count};
        ld_data  <= w_rx_byte;
        ld_count <= ld_count + 8'd1;
        r_sum    <= r_sum + w_rx_byte;
        r_rem    <= r_rem - 9'd1;
      end else if (w_byte && r_state == ST_CSUM) begin
        ld_done <= (w_rx_byte == r_sum);
        ld_err  <= (w_rx_byte != r_sum);
      end
    end
  end
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: randomized and directed frame tests against a byte-stream reference model
module tb_uart_prog_loader;
  localparam int CPB = 8;
  localparam int TO = 300;
  localparam logic [15:0] BASE = 16'h0000;
  localparam logic [7:0] HDR = 8'hA5;
  logic clk = 1'b0, rst = 1'b1, rxd = 1'b1, load_en = 1'b0;
  logic [15:0] ld_addr;
  logic [7:0] ld_data, ld_count;
  logic ld_write, ld_busy, ld_done, ld_err;
  int errors = 0, checks = 0;
  logic [23:0] got_w[$], exp_w[$];
  logic exp_done, exp_err;
  logic [7:0] exp_count;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .HEADER(HDR), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .load_en(load_en),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_write(ld_write), .ld_busy(ld_busy),
    .ld_done(ld_done), .ld_err(ld_err), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  // every cycle with the strobe high is one RAM write, so a stretched strobe shows up as an extra entry
  always @(negedge clk) if (ld_write) got_w.push_back({ld_addr, ld_data});

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tx_byte(input logic [7:0] b, input logic stop = 1'b1, input int gap = 2);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int maxgap);
    foreach (s[i]) tx_byte(s[i], 1'b1, $urandom_range(maxgap, 0));
    repeat (12) @(negedge clk);
  endtask

  // reference: locate the first header, take LEN (0 = 256) data bytes, compare the byte after them to their sum
  task automatic model(input logic [7:0] s[$]);
    int h, n;
    logic [7:0] sum;
    h = 0;
    while (s[h] != HDR) h++;
    n = (s[h+1] == 8'h00) ? 256 : int'(s[h+1]);
    sum = 8'h00;
    exp_w.delete();
    for (int k = 0; k < n; k++) begin
      exp_w.push_back({BASE + 16'(k), s[h+2+k]});
      sum = sum + s[h+2+k];
    end
    exp_done = (s[h+2+n] == sum);
    exp_err = !exp_done;
    exp_count = 8'(n);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ld_addr, ld_data, ld_write, ld_busy, ld_done, ld_err, ld_count} !== 37'd0) begin
      errors++;
      $display("FAIL reset outputs: got %h expected 0", {ld_addr, ld_data, ld_write, ld_busy, ld_done, ld_err, ld_count});
    end
    rst = 1'b0;
    load_en = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_directed;
    logic [7:0] s[$];
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        1: s = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
        default: s = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7E};
      endcase
      model(s);
      got_w.delete();
      send_stream(s, 3);
      checks++;
      if (got_w.size() != exp_w.size()) begin
        errors++;
        $display("FAIL directed%0d write count: got %0d expected %0d", k, got_w.size(), exp_w.size());
      end else foreach (exp_w[i]) begin
        checks++;
        if (got_w[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL directed%0d write%0d: got %h expected %h", k, i, got_w[i], exp_w[i]);
        end
      end
      checks++;
      if ({ld_done, ld_err, ld_busy, ld_count} !== {exp_done, exp_err, 1'b0, exp_count}) begin
        errors++;
        $display("FAIL directed%0d status done/err/busy/count: got %b%b%b %h expected %b%b0 %h",
                 k, ld_done, ld_err, ld_busy, ld_count, exp_done, exp_err, exp_count);
      end
    end
    checks++;
    if (ld_done !== 1'b1 || ld_count !== 8'h01) begin
      errors++;
      $display("FAIL directed leading-junk: got done=%b count=%h expected done=1 count=01", ld_done, ld_count);
    end
  endtask

  task automatic test_random;
    logic [7:0] s[$];
    logic [7:0] sum, j;
    int n;
    for (int f = 0; f < 4; f++) begin
      s.delete();
      for (int p = $urandom_range(2, 0); p > 0; p--) begin
        do j = 8'($urandom); while (j == HDR);
        s.push_back(j);
      end
      n = $urandom_range(12, 1);
      s.push_back(HDR);
      s.push_back(8'(n));
      sum = 8'h00;
      for (int i = 0; i < n; i++) begin
        j = 8'($urandom);
        s.push_back(j);
        sum = sum + j;
      end
      s.push_back($urandom_range(1, 0) ? sum : sum + 8'($urandom_range(255, 1)));
      model(s);
      got_w.delete();
      send_stream(s, 6);
      checks++;
      if (got_w.size() != exp_w.size()) begin
        errors++;
        $display("FAIL random%0d write count: got %0d expected %0d", f, got_w.size(), exp_w.size());
      end else foreach (exp_w[i]) begin
        checks++;
        if (got_w[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL random%0d write%0d: got %h expected %h", f, i, got_w[i], exp_w[i]);
        end
      end
      checks++;
      if ({ld_done, ld_err, ld_busy, ld_count} !== {exp_done, exp_err, 1'b0, exp_count}) begin
        errors++;
        $display("FAIL random%0d status done/err/busy/count: got %b%b%b %h expected %b%b0 %h",
                 f, ld_done, ld_err, ld_busy, ld_count, exp_done, exp_err, exp_count);
      end
    end
  endtask

  task automatic test_timeout;
    got_w.delete();
    tx_byte(HDR);
    tx_byte(8'h04);
    tx_byte(8'h01);
    tx_byte(8'h02);
    repeat (TO - 40) @(negedge clk);
    checks++;
    if (ld_busy !== 1'b1 || ld_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout early: got busy=%b err=%b expected busy=1 err=0", ld_busy, ld_err);
    end
    repeat (60) @(negedge clk);
    checks++;
    if ({ld_busy, ld_err, ld_done, ld_count} !== {3'b010, 8'h02}) begin
      errors++;
      $display("FAIL timeout expiry busy/err/done/count: got %b%b%b %h expected 010 02", ld_busy, ld_err, ld_done, ld_count);
    end
    checks++;
    if (got_w.size() != 2 || got_w[0] !== 24'h000001 || got_w[1] !== 24'h000102) begin
      errors++;
      $display("FAIL timeout writes: got %0d entries expected 000001,000102", got_w.size());
    end
  endtask

  task automatic test_ferr;
    got_w.delete();
    tx_byte(HDR);
    tx_byte(8'h02);
    tx_byte(8'h55, 1'b0, 4);
    repeat (12) @(negedge clk);
    checks++;
    if (got_w.size() != 0) begin
      errors++;
      $display("FAIL ferr writes: got %0d expected 0", got_w.size());
    end
    checks++;
    if ({ld_busy, ld_err, ld_done, ld_count} !== {3'b010, 8'h00}) begin
      errors++;
      $display("FAIL ferr busy/err/done/count: got %b%b%b %h expected 010 00", ld_busy, ld_err, ld_done, ld_count);
    end
  endtask

  task automatic test_abort;
    got_w.delete();
    tx_byte(HDR);
    tx_byte(8'h05);
    tx_byte(8'h01);
    tx_byte(8'h02);
    repeat (4) @(negedge clk);
    load_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({ld_busy, ld_err, ld_done, ld_count} !== {3'b010, 8'h02} || got_w.size() != 2) begin
      errors++;
      $display("FAIL abort busy/err/done/count: got %b%b%b %h writes=%0d expected 010 02 writes=2",
               ld_busy, ld_err, ld_done, ld_count, got_w.size());
    end
  endtask

  task automatic test_idle_disabled;
    got_w.delete();
    send_stream('{8'hA5, 8'h01, 8'h7E, 8'h7E}, 2);
    checks++;
    if ({ld_busy, ld_err, ld_done, ld_count} !== {3'b010, 8'h02} || got_w.size() != 0) begin
      errors++;
      $display("FAIL disabled busy/err/done/count: got %b%b%b %h writes=%0d expected 010 02 writes=0",
               ld_busy, ld_err, ld_done, ld_count, got_w.size());
    end
    load_en = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_full_256;
    logic [7:0] s[$];
    s = '{8'hA5, 8'h00};
    for (int i = 0; i < 256; i++) s.push_back(8'(i));
    s.push_back(8'h80);
    model(s);
    got_w.delete();
    send_stream(s, 0);
    checks++;
    if (got_w.size() != 256) begin
      errors++;
      $display("FAIL full256 write count: got %0d expected 256", got_w.size());
    end else foreach (exp_w[i]) begin
      checks++;
      if (got_w[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL full256 write%0d: got %h expected %h", i, got_w[i], exp_w[i]);
      end
    end
    checks++;
    if ({ld_done, ld_err, ld_busy, ld_count} !== {3'b100, 8'h00}) begin
      errors++;
      $display("FAIL full256 status done/err/busy/count: got %b%b%b %h expected 100 00", ld_done, ld_err, ld_busy, ld_count);
    end
  endtask

  task automatic test_reset_mid;
    tx_byte(HDR);
    tx_byte(8'h05);
    tx_byte(8'h01);
    repeat (4) @(negedge clk);
    checks++;
    if (ld_busy !== 1'b1 || ld_data !== 8'h01) begin
      errors++;
      $display("FAIL reset-mid precondition: got busy=%b data=%h expected busy=1 data=01", ld_busy, ld_data);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ld_addr, ld_data, ld_write, ld_busy, ld_done, ld_err, ld_count} !== 37'd0) begin
      errors++;
      $display("FAIL reset-mid outputs: got %h expected 0", {ld_addr, ld_data, ld_write, ld_busy, ld_done, ld_err, ld_count});
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_timeout;
    test_ferr;
    test_abort;
    test_idle_disabled;
    test_full_256;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Upstream feeder for the 8-bit machine's program memory. Receives a framed program image over a UART RX line and writes it byte-by-byte into RAM.
- Replaces manual entry through the D switches and A1 key.
- Sits beside the memory block in the top level. Top muxes ld_addr/ld_data/ld_write onto the memory address/data/write inputs while ld_busy is high.
- Reports status on LEDs: busy/done/error.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit (synthesis value 434 = 50 MHz / 115200)
BASE_ADDR, 16'h0000, first RAM address written
HEADER, 8'hA5, frame start byte
TIMEOUT_CYC, 65535, max idle clk cycles between bytes inside a frame

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rxd  input  1  UART receive line, asynchronous, idle high
load_en  input  1  loader permitted (top drives from mode switch); low = abort/ignore
ld_addr  output  16  RAM write address
ld_data  output  8  RAM write data
ld_write  output  1  one-cycle RAM write strobe
ld_busy  output  1  frame in progress (LEN, DATA or CSUM state)
ld_done  output  1  sticky: last frame loaded with good checksum
ld_err  output  1  sticky: last frame failed (checksum, framing, timeout, abort)
ld_count  output  8  data bytes written in current/last frame (low 8 bits)

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0, FSM to IDLE, RX to idle, checksum/counters 0. Reset mid-frame discards the frame; bytes already written stay in RAM.
- RX sub-module (8N1, LSB first):
  - rxd passes through a 2-FF synchronizer.
  - Start is detected on a high-to-low transition; low is re-checked at CLKS_PER_BIT/2. If high, treat as a glitch and return to idle.
  - Data bits are sampled every CLKS_PER_BIT thereafter.
  - Stop bit sampled 0 -> rx_ferr pulse, no rx_valid.
  - A good byte gives a 1-cycle rx_valid with rx_byte.
- Frame format: HEADER, LEN (0 means 256), LEN data bytes, CSUM = 8-bit sum of data bytes mod 256.
- FSM states:
  - IDLE: rx_valid with byte==HEADER and load_en=1 -> LEN; clear ld_done, ld_err, ld_count, sum. Other bytes ignored.
  - LEN: rx_valid -> latch remaining = (byte==0 ? 256 : byte), 9-bit -> DATA.
  - DATA: per rx_valid:
    - ld_write=1 for exactly one cycle, the cycle after rx_valid.
    - ld_addr = BASE_ADDR + index (16-bit, wraps mod 2^16).
    - ld_data = byte; index++, ld_count++, sum += byte, remaining--.
    - remaining reaching 0 -> CSUM.
  - CSUM: rx_valid: byte==sum -> ld_done=1; else ld_err=1. -> IDLE.
- Errors inside LEN/DATA/CSUM all set ld_err=1 and go to IDLE:
  - rx_ferr;
  - TIMEOUT_CYC cycles with no rx_valid (counter restarts on each rx_valid);
  - load_en falling.
- ld_busy = state in {LEN, DATA, CSUM}.
- ld_addr/ld_data hold their last values between strobes.
- load_en=0 in IDLE: bytes received but ignored; no flag changes.
- Simultaneous rx_valid and timeout expiry in the same cycle: the byte wins and the timeout counter reloads.

Decomposition:
- Shared package: FSM state encoding (IDLE, LEN, DATA, CSUM), default HEADER, UART sim/synthesis CLKS_PER_BIT constants.
- One sub-module: uart_rx (clk, rst, rxd -> rx_valid, rx_byte, rx_ferr), parameterised by CLKS_PER_BIT.

Test Plan:
- Send A5 03 11 22 33 66 with load_en=1 -> writes 11@0000, 22@0001, 33@0002, one ld_write each. Then ld_done=1, ld_err=0, ld_count=3, ld_busy=0.
- Send A5 02 10 20 31 (bad checksum, expected 30) -> two writes occur; ld_err=1, ld_done=0, ld_count=2.
- Send 00 FF A5 01 7E 7E -> leading bytes ignored, single write 7E@0000, ld_done=1.
- Send A5 04 01 02, then stay silent TIMEOUT_CYC+1 cycles -> ld_err=1, ld_busy=0, ld_count=2.
- Send A5 02 55 with the stop bit of the 55 byte held low -> no write for that byte, ld_err=1. Separately, drop load_en mid-DATA -> ld_err=1, FSM IDLE.
- Send A5 00 plus 256 bytes (0x00..0xFF) and CSUM 80 -> 256 writes at 0000..00FF, ld_count=00 (wrapped), ld_done=1. Assert rst mid-frame in a rerun -> all outputs 0 next cycle.
